// File: rtl/debugger_uart_rx.sv
// debugger_uart_rx
//   Receive half of the debugger UART. The asynchronous RXD pin is synchronised, 8N1 frames are
//   deframed with a 16x oversampling FSM (majority vote of samples 7/8/9 in each bit period) and
//   good bytes are queued in a small FIFO. Framing and overrun faults are sticky flags.
//
// Ports
//   CLK        in   system clock
//   RESET_n    in   asynchronous active-low reset
//   RXD_PIN    in   serial input, idle high, asynchronous to CLK
//   READY      out  FIFO non-empty; DATA holds the oldest byte
//   DATA       out  head-of-FIFO byte, valid while READY=1 (holds last value otherwise)
//   READ       in   consumer read strobe; accepted, no effect on state
//   CLEAR      in   consumer release; a rising edge pops one byte
//   FRAME_ERR  out  sticky: a stop bit was sampled low
//   OVERRUN    out  sticky: a byte arrived while the FIFO was full
//   ERR_CLR    in   one-cycle pulse clearing FRAME_ERR and OVERRUN
module debugger_uart_rx #(
    parameter int unsigned CLK_FREQ = 27_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned DEPTH    = 16
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       RXD_PIN,
    output logic       READY,
    output logic [7:0] DATA,
    input  logic       READ,
    input  logic       CLEAR,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    input  logic       ERR_CLR
);

    // Oversample divider, rounded to nearest; never below 1.
    localparam int unsigned DIV_RAW = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    // ------------------------------------------------------------------
    // Input synchroniser; both stages reset to idle-high so no false start bit follows reset.
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RXD_PIN;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // 16x tick divider; restarted on entry to START so the sample points line up with the edge.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;
    logic             div_restart;

    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            div_cnt_q <= '0;
        end else if (div_restart || tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_e  state_q, state_d;
    logic [3:0] sub_q, sub_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       s7_q, s7_d;
    logic       s8_q, s8_d;
    logic       maj;
    logic       push;
    logic       frame_evt;

    // Samples 7 and 8 are held; sample 9 is the live synced input on the sub-count-9 tick.
    assign maj = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= StIdle;
            sub_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        s7_d        = s7_q;
        s8_d        = s8_q;
        div_restart = 1'b0;
        push        = 1'b0;
        frame_evt   = 1'b0;

        if (state_q != StIdle && tick) begin
            sub_d = sub_q + 4'd1;
            if (sub_q == 4'd7) s7_d = rx_sync_q;
            if (sub_q == 4'd8) s8_d = rx_sync_q;
        end

        unique case (state_q)
            StIdle: begin
                // Start detection runs every CLK, not just on ticks.
                if (!rx_sync_q) begin
                    state_d     = StStart;
                    sub_d       = '0;
                    div_restart = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    if (sub_q == 4'd9 && maj) begin
                        state_d = StIdle;
                    end else if (sub_q == 4'd15) begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (sub_q == 4'd9) shift_d = {maj, shift_q[7:1]};
                    if (sub_q == 4'd15) begin
                        if (bit_q == 3'd7) state_d = StStop;
                        else               bit_d   = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (tick && sub_q == 4'd9) begin
                    if (maj) push      = 1'b1;
                    else     frame_evt = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [DEPTH];
    logic          empty, full;
    logic          clear_q;
    logic          pop;
    logic          push_ok;
    logic          overrun_evt;
    logic          ready_q;
    logic [7:0]    data_q;
    logic          read_unused;

    assign read_unused = READ;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop         = CLEAR && !clear_q && ready_q && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok     = push && (!full || pop);
    assign overrun_evt = push && full && !pop;

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            clear_q  <= 1'b0;
            ready_q  <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            clear_q <= CLEAR;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            ready_q <= !empty;
            if (!empty) data_q <= mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a same-cycle error beats ERR_CLR.
    // ------------------------------------------------------------------
    logic frame_err_q, overrun_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_evt)    frame_err_q <= 1'b1;
            else if (ERR_CLR) frame_err_q <= 1'b0;
            if (overrun_evt)  overrun_q   <= 1'b1;
            else if (ERR_CLR) overrun_q   <= 1'b0;
        end
    end

    assign READY     = ready_q;
    assign DATA      = data_q;
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;

endmodule
